// File: rtl/hmac_msg_packer.sv
`default_nettype none
// ============================================================================
// Module   : hmac_msg_packer
// Purpose  : Byte-to-word front end for the HMAC-SHA3-512 controller message
//            port. Packs an 8-bit byte stream into little-endian 32-bit words,
//            buffers them in a show-ahead FIFO, and reports the byte length of
//            each completed message.
// Ports    : clk, reset_n        - clock, asynchronous active-low reset
//            clear               - synchronous flush of FIFO, packer, length
//            in_byte/in_valid/in_last/in_ready - byte stream input
//            msg_word/msg_valid/msg_last/msg_ready - word stream output
//            msg_len_bytes/msg_len_valid - completed message length + pulse
//            len_overflow        - sticky length saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module hmac_msg_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      msg_word,
    output logic             msg_valid,
    output logic             msg_last,
    input  logic             msg_ready,
    output logic [LEN_W-1:0] msg_len_bytes,
    output logic             msg_len_valid,
    output logic             len_overflow
);

    localparam int                 c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]   c_LEN_MAX = {LEN_W{1'b1}};

    // FIFO storage: bit 32 is the last flag, bits 31:0 the packed word.
    logic [32:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Packer state: bytes already collected for the current word.
    logic [1:0]         r_byte_idx;
    logic [23:0]        r_accum;

    // Length tracking.
    logic [LEN_W-1:0]   r_len_cnt;
    logic [LEN_W-1:0]   r_len_bytes;
    logic               r_len_valid;
    logic               r_len_ovf;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_word;
    logic [32:0]        w_head;
    logic               w_len_sat;
    logic [LEN_W-1:0]   w_len_next;

    assign msg_valid = (r_count != '0);
    assign in_ready  = (r_count < c_DEPTH);

    // clear wins over both handshakes: nothing is accepted or popped.
    assign w_accept  = in_valid & in_ready & ~clear;
    assign w_pop     = msg_valid & msg_ready & ~clear;
    assign w_push    = w_accept & ((r_byte_idx == 2'd3) | in_last);

    // Merge the incoming byte into its lane. Lanes above the current index
    // are still zero in r_accum, so a short final word is zero-padded.
    always_comb begin
        w_word = {8'h00, r_accum};
        case (r_byte_idx)
            2'd0:    w_word[7:0]   = in_byte;
            2'd1:    w_word[15:8]  = in_byte;
            2'd2:    w_word[23:16] = in_byte;
            default: w_word[31:24] = in_byte;
        endcase
    end

    // Empty FIFO presents an all-zero head.
    assign w_head   = r_mem[r_rd_ptr];
    assign msg_word = msg_valid ? w_head[31:0] : 32'h0;
    assign msg_last = msg_valid & w_head[32];

    assign w_len_sat  = (r_len_cnt == c_LEN_MAX);
    assign w_len_next = w_len_sat ? r_len_cnt : r_len_cnt + 1'b1;

    assign msg_len_bytes = r_len_bytes;
    assign msg_len_valid = r_len_valid;
    assign len_overflow  = r_len_ovf;

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, w_word};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_idx <= 2'd0;
            r_accum    <= 24'h0;
        end else if (clear) begin
            r_byte_idx <= 2'd0;
            r_accum    <= 24'h0;
        end else if (w_push) begin
            r_byte_idx <= 2'd0;
            r_accum    <= 24'h0;
        end else if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            r_accum    <= w_word[23:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len_cnt   <= '0;
            r_len_bytes <= '0;
            r_len_valid <= 1'b0;
            r_len_ovf   <= 1'b0;
        end else if (clear) begin
            // Reported length of the previous message is kept.
            r_len_cnt   <= '0;
            r_len_valid <= 1'b0;
            r_len_ovf   <= 1'b0;
        end else begin
            r_len_valid <= w_accept & in_last;
            if (w_accept) begin
                if (in_last) begin
                    r_len_bytes <= w_len_next;
                    r_len_cnt   <= '0;
                end else begin
                    r_len_cnt   <= w_len_next;
                end
                // A zero count means this byte opens a new message; the count
                // saturates, so it never returns to zero mid-message.
                if (w_len_sat) begin
                    r_len_ovf <= 1'b1;
                end else if (r_len_cnt == '0) begin
                    r_len_ovf <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
